// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone B4 pipelined slave mux and its
// address decoder.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] WB_ERR_NONE     = 2'b00;
  localparam logic [1:0] WB_ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] WB_ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  // A one-slave system still needs a one-bit index to keep vectors legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority address decoder: the lowest-numbered slave whose
// masked base matches the address wins, and the offset is the unmasked part.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int                      N_SLAVES   = 4,
  parameter int                      AW         = 32,
  parameter logic [N_SLAVES*AW-1:0]  SLAVE_BASE = '0,
  parameter logic [N_SLAVES*AW-1:0]  SLAVE_MASK = '0,
  parameter int                      IW         = idx_width(N_SLAVES)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic [AW-1:0] offset
);

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path
    // with no matching slave would infer a latch.
    hit    = 1'b0;
    idx    = '0;
    offset = addr;
    // Walking downwards lets the lowest matching index overwrite the others.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
        hit    = 1'b1;
        idx    = IW'(i);
        offset = addr & ~SLAVE_MASK[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone B4 pipelined interconnect: one master, N_SLAVES slaves, one
// outstanding transfer, bus error on unmapped addresses and on ack timeout.
module wb_slave_mux
  import wb_pkg::*;
#(
  parameter int                     N_SLAVES   = 4,
  parameter int                     AW         = 32,
  parameter int                     DW         = 32,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
  parameter int unsigned            TIMEOUT    = 255,
  parameter logic [31:0]            ERR_DATA   = WB_ERR_DATA
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [AW-1:0]          i_wb_addr,
  input  logic [DW-1:0]          i_wb_data,
  input  logic [DW/8-1:0]        i_wb_sel,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic [DW-1:0]          o_wb_data,
  output logic [N_SLAVES-1:0]    o_s_cyc,
  output logic [N_SLAVES-1:0]    o_s_stb,
  output logic                   o_s_we,
  output logic [AW-1:0]          o_s_addr,
  output logic [DW-1:0]          o_s_data,
  output logic [DW/8-1:0]        o_s_sel,
  input  logic [N_SLAVES-1:0]    i_s_stall,
  input  logic [N_SLAVES-1:0]    i_s_ack,
  input  logic [N_SLAVES*DW-1:0] i_s_data,
  output logic [1:0]             o_err_code,
  output logic [AW-1:0]          o_err_addr
);

  localparam int            IW          = idx_width(N_SLAVES);
  localparam int            CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [DW-1:0] ERR_WORD    = DW'(ERR_DATA);

  state_t                state;
  logic [IW-1:0]         cur_idx;
  logic [AW-1:0]         req_addr;
  logic [CW-1:0]         cnt;

  logic                  dec_hit;
  logic [IW-1:0]         dec_idx;
  logic [AW-1:0]         dec_offset;
  logic [N_SLAVES-1:0]   dec_onehot;

  logic                  request;
  logic                  cur_stall;
  logic                  cur_ack;
  logic                  ack_ok;
  logic                  timed_out;
  logic [DW-1:0]         cur_rdata;

  wb_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .AW         (AW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IW         (IW)
  ) u_decode (
    .addr   (i_wb_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  always_comb begin
    dec_onehot          = '0;
    dec_onehot[dec_idx] = 1'b1;
  end

  assign request    = i_wb_cyc && i_wb_stb;
  assign cur_stall  = i_s_stall[cur_idx];
  assign cur_ack    = i_s_ack[cur_idx];
  assign cur_rdata  = i_s_data[DW*int'(cur_idx) +: DW];
  // While the strobe is still stalled, an ack only counts once the stall drops.
  assign ack_ok     = cur_ack && ((state == ST_WAIT) || !cur_stall);
  assign timed_out  = (cnt == TIMEOUT_CNT);
  assign o_wb_stall = (state != ST_IDLE);

  // Preloaded to 1 while idle so it equals the cycle number of the access;
  // it then saturates at TIMEOUT rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= CW'(1);
    end else if (cnt != TIMEOUT_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      cur_idx    <= '0;
      req_addr   <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_data  <= '0;
      o_s_cyc    <= '0;
      o_s_stb    <= '0;
      o_s_we     <= 1'b0;
      o_s_addr   <= '0;
      o_s_data   <= '0;
      o_s_sel    <= '0;
      o_err_code <= WB_ERR_NONE;
      o_err_addr <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (request) begin
            req_addr <= i_wb_addr;
            if (dec_hit) begin
              cur_idx  <= dec_idx;
              o_s_cyc  <= dec_onehot;
              o_s_stb  <= dec_onehot;
              o_s_we   <= i_wb_we;
              o_s_addr <= dec_offset;
              o_s_data <= i_wb_data;
              o_s_sel  <= i_wb_sel;
              state    <= ST_REQ;
            end else begin
              o_wb_ack   <= 1'b1;
              o_wb_err   <= 1'b1;
              o_wb_data  <= ERR_WORD;
              o_err_code <= WB_ERR_UNMAPPED;
              o_err_addr <= i_wb_addr;
              state      <= ST_ERR;
            end
          end
        end

        ST_REQ, ST_WAIT: begin
          if (!i_wb_cyc) begin
            // Master abort: release the slave silently.
            o_s_cyc <= '0;
            o_s_stb <= '0;
            state   <= ST_IDLE;
          end else if (ack_ok) begin
            // Checked before the timeout so an ack on the last cycle wins.
            o_wb_ack  <= 1'b1;
            o_wb_data <= cur_rdata;
            o_s_cyc   <= '0;
            o_s_stb   <= '0;
            state     <= ST_IDLE;
          end else if (timed_out) begin
            o_wb_ack   <= 1'b1;
            o_wb_err   <= 1'b1;
            o_wb_data  <= ERR_WORD;
            o_err_code <= WB_ERR_TIMEOUT;
            o_err_addr <= req_addr;
            o_s_cyc    <= '0;
            o_s_stb    <= '0;
            state      <= ST_IDLE;
          end else if ((state == ST_REQ) && !cur_stall) begin
            o_s_stb <= '0;
            state   <= ST_WAIT;
          end
        end

        ST_ERR: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Self-checking bench for wb_slave_mux: directed scenarios followed by random
// transfers, all predicted by a cycle-level model of the mux's rules.
module tb_wb_slave_mux;
  import wb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [N*AW-1:0] BASES = {32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASKS = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFFFF_0000};

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_wb_cyc = 1'b0;
  logic            i_wb_stb = 1'b0;
  logic            i_wb_we = 1'b0;
  logic [AW-1:0]   i_wb_addr = '0;
  logic [DW-1:0]   i_wb_data = '0;
  logic [DW/8-1:0] i_wb_sel = '0;
  logic            o_wb_stall;
  logic            o_wb_ack;
  logic            o_wb_err;
  logic [DW-1:0]   o_wb_data;
  logic [N-1:0]    o_s_cyc;
  logic [N-1:0]    o_s_stb;
  logic            o_s_we;
  logic [AW-1:0]   o_s_addr;
  logic [DW-1:0]   o_s_data;
  logic [DW/8-1:0] o_s_sel;
  logic [N-1:0]    i_s_stall = '0;
  logic [N-1:0]    i_s_ack = '0;
  logic [N*DW-1:0] i_s_data = '0;
  logic [1:0]      o_err_code;
  logic [AW-1:0]   o_err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference address map and the last-error registers as the model sees them.
  logic [31:0] base_tab [N] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0000, 32'h4000_0000};
  logic [31:0] mask_tab [N] = '{32'hFFFF_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};
  logic [1:0]  m_err_code = 2'b00;
  logic [31:0] m_err_addr = '0;

  always #5 i_clk = ~i_clk;

  wb_slave_mux #(
    .N_SLAVES   (N),
    .AW         (AW),
    .DW         (DW),
    .SLAVE_BASE (BASES),
    .SLAVE_MASK (MASKS),
    .TIMEOUT    (TO),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_sel   (i_wb_sel),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_wb_data  (o_wb_data),
    .o_s_cyc    (o_s_cyc),
    .o_s_stb    (o_s_stb),
    .o_s_we     (o_s_we),
    .o_s_addr   (o_s_addr),
    .o_s_data   (o_s_data),
    .o_s_sel    (o_s_sel),
    .i_s_stall  (i_s_stall),
    .i_s_ack    (i_s_ack),
    .i_s_data   (i_s_data),
    .o_err_code (o_err_code),
    .o_err_addr (o_err_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(o_wb_stall), 32'h0);
    check({tag, "_ack"},   32'(o_wb_ack),   32'h0);
    check({tag, "_err"},   32'(o_wb_err),   32'h0);
    check({tag, "_rdata"}, o_wb_data,       32'h0);
    check({tag, "_scyc"},  32'(o_s_cyc),    32'h0);
    check({tag, "_sstb"},  32'(o_s_stb),    32'h0);
    check({tag, "_swe"},   32'(o_s_we),     32'h0);
    check({tag, "_saddr"}, o_s_addr,        32'h0);
    check({tag, "_sdata"}, o_s_data,        32'h0);
    check({tag, "_ssel"},  32'(o_s_sel),    32'h0);
    check({tag, "_ecode"}, 32'(o_err_code), 32'h0);
    check({tag, "_eaddr"}, o_err_addr,      32'h0);
  endtask

  // Present one request once the mux is ready; the caller is then in cycle 1.
  task automatic issue(input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] sel);
    int guard;
    guard = 0;
    while (o_wb_stall && guard < 8) begin
      step();
      guard++;
    end
    check("ready_before_request", 32'(o_wb_stall), 32'h0);
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = wdata;
    i_wb_sel  = sel;
    step();
    i_wb_stb = 1'b0;
  endtask

  // Full transfer. The slave holds stall for stall_n cycles and raises ack in
  // cycle ack_cyc (0 = never), both counted from acceptance.
  task automatic access(input logic [31:0] addr, input int stall_n, input int ack_cyc);
    int          idx;
    int          exp_end;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] slv_data [N];
    logic [3:0]  oh;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;

    idx   = model_decode(addr);
    we    = 1'($urandom);
    wdata = $urandom;
    sel   = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++) begin
      slv_data[i] = $urandom;
      i_s_data[i*DW +: DW] = slv_data[i];
    end
    i_s_stall = '0;
    i_s_ack   = '0;

    issue(addr, we, wdata, sel);

    if (idx < 0) begin
      m_err_code = 2'b01;
      m_err_addr = addr;
      check("unmapped_ack",   32'(o_wb_ack),   32'h1);
      check("unmapped_err",   32'(o_wb_err),   32'h1);
      check("unmapped_rdata", o_wb_data,       32'hDEAD_BEEF);
      check("unmapped_scyc",  32'(o_s_cyc),    32'h0);
      check("unmapped_ecode", 32'(o_err_code), 32'(m_err_code));
      check("unmapped_eaddr", o_err_addr,      m_err_addr);
      i_wb_cyc = 1'b0;
      step();
      check("unmapped_ack_pulse", 32'(o_wb_ack), 32'h0);
      check("unmapped_err_pulse", 32'(o_wb_err), 32'h0);
      return;
    end

    oh = 4'(1 << idx);
    if (ack_cyc != 0 && ack_cyc >= stall_n + 1 && ack_cyc <= TO) begin
      exp_end   = ack_cyc + 1;
      exp_err   = 1'b0;
      exp_rdata = slv_data[idx];
    end else begin
      exp_end    = TO + 1;
      exp_err    = 1'b1;
      exp_rdata  = 32'hDEAD_BEEF;
      m_err_code = 2'b10;
      m_err_addr = addr;
    end

    check("slave_addr", o_s_addr,        addr & ~mask_tab[idx]);
    check("slave_we",   32'(o_s_we),     32'(we));
    check("slave_data", o_s_data,        wdata);
    check("slave_sel",  32'(o_s_sel),    32'(sel));

    for (int c = 1; c <= exp_end; c++) begin
      if (c > 1) step();
      check("wb_ack",   32'(o_wb_ack),   32'(c == exp_end));
      check("wb_err",   32'(o_wb_err),   32'(c == exp_end && exp_err));
      check("wb_stall", 32'(o_wb_stall), 32'(c < exp_end));
      check("s_cyc",    32'(o_s_cyc),    (c < exp_end) ? 32'(oh) : 32'h0);
      check("s_stb",    32'(o_s_stb),    (c < exp_end && c <= stall_n + 1) ? 32'(oh) : 32'h0);
      if (c == exp_end) begin
        check("wb_rdata", o_wb_data,       exp_rdata);
        check("err_code", 32'(o_err_code), 32'(m_err_code));
        check("err_addr", o_err_addr,      m_err_addr);
        i_s_stall = '0;
        i_s_ack   = '0;
      end else begin
        i_s_stall = (c <= stall_n) ? oh : 4'h0;
        i_s_ack   = (c == ack_cyc) ? oh : 4'h0;
      end
    end
    i_wb_cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    int          stall_n;
    int          ack_cyc;

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    step();

    // Slave 0, one-cycle ack: acknowledged three cycles after acceptance.
    access(32'h0000_0010, 0, 2);
    // Overlapping slaves 1 and 2: the lower index must be selected.
    access(32'h2000_0000, 0, 2);
    // Unmapped address, and the first address just above slave 0's window.
    access(32'hF000_0004, 0, 0);
    access(32'h0001_0000, 0, 0);
    // Silent slave: timeout response TIMEOUT+1 cycles after acceptance.
    access(32'h4000_0100, 0, 0);
    // Stall for three cycles, then ack exactly on the timeout cycle.
    access(32'h4000_0040, 3, TO);
    // Ack in the same cycle the stall drops, then stall past the timeout.
    access(32'h0000_0030, 2, 3);
    access(32'h2345_6780, TO + 2, 0);

    // Master abort in WAIT: slave released on the next edge, late ack ignored.
    i_s_stall = '0;
    i_s_ack   = '0;
    issue(32'h0000_0080, 1'b0, 32'h0, 4'hF);
    step();
    check("abort_wait_scyc", 32'(o_s_cyc), 32'h1);
    check("abort_wait_sstb", 32'(o_s_stb), 32'h0);
    i_wb_cyc = 1'b0;
    step();
    check("abort_scyc",  32'(o_s_cyc),    32'h0);
    check("abort_stall", 32'(o_wb_stall), 32'h0);
    check("abort_ack",   32'(o_wb_ack),   32'h0);
    i_s_ack = 4'h1;
    step();
    i_s_ack = '0;
    check("abort_late_ack", 32'(o_wb_ack), 32'h0);
    check("abort_late_err", 32'(o_wb_err), 32'h0);
    step();
    check("abort_late_ack2", 32'(o_wb_ack), 32'h0);

    // Asynchronous reset in the middle of WAIT.
    issue(32'h4000_0200, 1'b1, 32'h1234_5678, 4'h3);
    step();
    check("rst_wait_scyc", 32'(o_s_cyc), 32'h8);
    #2;
    i_rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    i_rst      = 1'b1;
    i_wb_cyc   = 1'b0;
    m_err_code = 2'b00;
    m_err_addr = '0;
    step();
    access(32'h4000_0300, 1, 4);

    // Random transfers against the model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0:       addr = {16'h0000, 16'($urandom)};
        1:       addr = 32'h2000_0000 | ($urandom & 32'h00FF_FFFF);
        2:       addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
        3:       addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: addr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
      endcase
      stall_n = $urandom_range(0, 4);
      ack_cyc = ($urandom_range(0, 5) == 0) ? 0 : stall_n + 1 + $urandom_range(0, 5);
      access(addr, stall_n, ack_cyc);
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
